stream_compressor_v2: RTL and testbench

- Parametrised successor to the fixed 8x32-bit compressor top.
- Per input beat of NUM_DATA words, emits one mask word (bitmap of nonzero kept words) followed by only the nonzero words. Groups are packed densely into NUM_DATA-word output beats.
- Per packet, adds a trailer word carrying the original word count, and supports a per-packet bypass mode.
- Sits between the host stream interface and the DMA/output stream; a matching decompressor consumes its output.

---
 rtl/stream_compressor_v2.sv | 220 ++++++++++++++++++++++
 tb/tb_stream_compressor_v2.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_compressor_v2.sv
// Zero-word stream compressor: each input beat becomes {mask, nonzero words}, packed densely
// into output beats, with a per-packet word-count trailer and an optional bypass mode.
module stream_compressor_v2 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_DATA   = 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH*NUM_DATA-1:0] data_in,
  input  logic                           tvalid_in,
  input  logic                           tlast_in,
  input  logic [NUM_DATA-1:0]            tkeep_in,
  output logic                           tready_out,
  input  logic                           bypass,
  output logic [DATA_WIDTH*NUM_DATA-1:0] data_out,
  output logic                           tvalid_out,
  output logic                           tlast_out,
  output logic [NUM_DATA-1:0]            tkeep_out,
  input  logic                           tready_in,
  output logic                           busy
);

  localparam int unsigned BufWords = 2 * NUM_DATA;
  localparam int unsigned FillW    = $clog2(BufWords + 1);
  localparam logic [FillW-1:0] NumW = FillW'(NUM_DATA);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {StIdle, StRun, StTrailer, StFlush} state_e;

  // Input stage
  logic                in_valid_q, in_last_q, in_byp_q;
  word_t               in_data_q [NUM_DATA];
  logic [NUM_DATA-1:0] in_keep_q, in_mask_q, in_mask_d;
  logic                expect_first_q, byp_pkt_q, byp_sel;
  logic                in_accept, in_consume;

  // Packer and output register
  state_e              state_q, state_d;
  word_t               buf_q [BufWords];
  word_t               buf_d [BufWords];
  word_t               shifted [BufWords];
  logic [FillW-1:0]    fill_q, fill_d, fill_after, grp_end, pos;
  logic [FillW-1:0]    slot [NUM_DATA];
  logic [NUM_DATA-1:0] sel;
  logic [CNT_WIDTH-1:0] count_q, count_d, cnt_base, cnt_next;
  logic [CNT_WIDTH:0]  pop, cnt_sum;
  logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [NUM_DATA-1:0] out_keep_q, out_keep_d;
  word_t               out_data_q [NUM_DATA];
  word_t               out_data_d [NUM_DATA];
  logic                out_free, emit_full, emit_final, space, trl_append;

  always_comb begin
    in_mask_d = '0;
    for (int i = 0; i < NUM_DATA; i++) begin
      in_mask_d[i] = tkeep_in[i] && (data_in[i*DATA_WIDTH +: DATA_WIDTH] != '0);
    end
  end

  // Mode is taken from the first beat of a packet and carried with every later beat.
  assign byp_sel    = expect_first_q ? bypass : byp_pkt_q;
  assign tready_out = reset & (~in_valid_q | in_consume);
  assign in_accept  = tvalid_in & tready_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_valid_q     <= 1'b0;
      in_last_q      <= 1'b0;
      in_byp_q       <= 1'b0;
      in_keep_q      <= '0;
      in_mask_q      <= '0;
      expect_first_q <= 1'b1;
      byp_pkt_q      <= 1'b0;
      for (int i = 0; i < NUM_DATA; i++) in_data_q[i] <= '0;
    end else if (in_accept) begin
      in_valid_q     <= 1'b1;
      in_last_q      <= tlast_in;
      in_byp_q       <= byp_sel;
      in_keep_q      <= tkeep_in;
      in_mask_q      <= in_mask_d;
      expect_first_q <= tlast_in;
      byp_pkt_q      <= byp_sel;
      for (int i = 0; i < NUM_DATA; i++) in_data_q[i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (in_consume) begin
      in_valid_q <= 1'b0;
    end
  end

  // Emission decision and the buffer occupancy left after it
  always_comb begin
    out_free   = !out_valid_q || tready_in;
    emit_full  = 1'b0;
    emit_final = 1'b0;
    if (state_q == StFlush) begin
      emit_full  = out_free && (fill_q > NumW);
      emit_final = out_free && (fill_q <= NumW) && !(out_valid_q && out_last_q);
    end else begin
      emit_full  = out_free && (fill_q >= NumW);
    end
    if (emit_full)       fill_after = fill_q - NumW;
    else if (emit_final) fill_after = '0;
    else                 fill_after = fill_q;
    space      = fill_after < NumW;
    in_consume = in_valid_q && ((state_q == StIdle) || (state_q == StRun)) && space;
    trl_append = (state_q == StTrailer) && space;
  end

  // Destination slot of every selected input word (the mask word, if any, sits at fill_after)
  always_comb begin
    sel = in_byp_q ? in_keep_q : in_mask_q;
    pos = fill_after + (in_byp_q ? '0 : FillW'(1));
    pop = '0;
    for (int s = 0; s < NUM_DATA; s++) begin
      slot[s] = pos;
      pos     = pos + FillW'(sel[s]);
      pop     = pop + (CNT_WIDTH+1)'(in_keep_q[s]);
    end
    grp_end = pos;
  end

  always_comb begin
    for (int j = 0; j < NUM_DATA; j++) begin
      shifted[j] = emit_full ? buf_q[j + NUM_DATA] : buf_q[j];
    end
    for (int j = NUM_DATA; j < BufWords; j++) begin
      shifted[j] = emit_full ? '0 : buf_q[j];
    end
    for (int j = 0; j < BufWords; j++) begin
      buf_d[j] = shifted[j];
      if (in_consume) begin
        if (!in_byp_q && (fill_after == FillW'(j))) buf_d[j] = word_t'(in_mask_q);
        for (int s = 0; s < NUM_DATA; s++) begin
          if (sel[s] && (slot[s] == FillW'(j))) buf_d[j] = in_data_q[s];
        end
      end
      if (trl_append && (fill_after == FillW'(j))) buf_d[j] = word_t'(count_q);
    end
    if (in_consume)      fill_d = grp_end;
    else if (trl_append) fill_d = fill_after + FillW'(1);
    else                 fill_d = fill_after;
  end

  always_comb begin
    out_valid_d = out_valid_q && !tready_in;
    out_last_d  = out_last_q;
    out_keep_d  = out_keep_q;
    out_data_d  = out_data_q;
    if (out_valid_q && tready_in) begin
      out_last_d = 1'b0;
      out_keep_d = '0;
      for (int j = 0; j < NUM_DATA; j++) out_data_d[j] = '0;
    end
    if (emit_full) begin
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      out_keep_d  = '1;
      for (int j = 0; j < NUM_DATA; j++) out_data_d[j] = buf_q[j];
    end else if (emit_final) begin
      out_valid_d = 1'b1;
      out_last_d  = 1'b1;
      for (int j = 0; j < NUM_DATA; j++) begin
        out_keep_d[j] = FillW'(j) < fill_q;
        out_data_d[j] = (FillW'(j) < fill_q) ? buf_q[j] : '0;
      end
    end
  end

  always_comb begin
    cnt_base = (state_q == StIdle) ? '0 : count_q;
    cnt_sum  = {1'b0, cnt_base} + pop;
    cnt_next = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    state_d  = state_q;
    count_d  = count_q;
    unique case (state_q)
      StIdle, StRun: begin
        if (in_consume) begin
          count_d = cnt_next;
          state_d = in_last_q ? (in_byp_q ? StFlush : StTrailer) : StRun;
        end
      end
      StTrailer: if (trl_append) state_d = StFlush;
      StFlush:   if (out_valid_q && out_last_q && tready_in) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      fill_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_keep_q  <= '0;
      for (int j = 0; j < BufWords; j++) buf_q[j] <= '0;
      for (int j = 0; j < NUM_DATA; j++) out_data_q[j] <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_keep_q  <= out_keep_d;
      for (int j = 0; j < BufWords; j++) buf_q[j] <= buf_d[j];
      for (int j = 0; j < NUM_DATA; j++) out_data_q[j] <= out_data_d[j];
    end
  end

  always_comb begin
    data_out = '0;
    for (int j = 0; j < NUM_DATA; j++) data_out[j*DATA_WIDTH +: DATA_WIDTH] = out_data_q[j];
  end

  assign tvalid_out = out_valid_q;
  assign tlast_out  = out_last_q;
  assign tkeep_out  = out_keep_q;
  assign busy       = (state_q != StIdle) || (fill_q != '0) || out_valid_q;

endmodule

// File: tb/tb_stream_compressor_v2.sv
// Scoreboard bench for stream_compressor_v2: expected output beats are queued as stimulus is
// issued and a negedge monitor pops and compares each transferred beat.
module tb_stream_compressor_v2;

  typedef struct packed {
    logic [255:0] d;
    logic [7:0]   k;
    logic         l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] data_in = '0;
  logic         tvalid_in = 1'b0;
  logic         tlast_in = 1'b0;
  logic [7:0]   tkeep_in = '0;
  logic         tready_out;
  logic         bypass = 1'b0;
  logic [255:0] data_out;
  logic         tvalid_out;
  logic         tlast_out;
  logic [7:0]   tkeep_out;
  logic         tready_in = 1'b1;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned stall_lo = 32'hFFFF_FFFF;
  int unsigned stall_hi = 0;
  logic saw_bp = 1'b0;

  beat_t       sbq[$];
  logic [31:0] ew[$];

  stream_compressor_v2 #(.DATA_WIDTH(32), .NUM_DATA(8), .CNT_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .data_in    (data_in),
    .tvalid_in  (tvalid_in),
    .tlast_in   (tlast_in),
    .tkeep_in   (tkeep_in),
    .tready_out (tready_out),
    .bypass     (bypass),
    .data_out   (data_out),
    .tvalid_out (tvalid_out),
    .tlast_out  (tlast_out),
    .tkeep_out  (tkeep_out),
    .tready_in  (tready_in),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    tready_in <= !((cyc >= stall_lo) && (cyc <= stall_hi));
  end

  // Scoreboard monitor
  beat_t        mon_e;
  logic [255:0] mon_m;
  always @(negedge clk) begin
    if (rst_n && tvalid_out && tready_in) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data=%h keep=%h last=%b, required no beat",
                 data_out, tkeep_out, tlast_out);
      end else begin
        mon_e = sbq.pop_front();
        for (int w = 0; w < 8; w++) mon_m[w*32 +: 32] = {32{mon_e.k[w]}};
        if (((data_out & mon_m) !== mon_e.d) || (tkeep_out !== mon_e.k) ||
            (tlast_out !== mon_e.l)) begin
          errors++;
          $display("FAIL out_beat: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                   data_out & mon_m, tkeep_out, tlast_out, mon_e.d, mon_e.k, mon_e.l);
        end
      end
    end
  end

  // Output must hold while stalled
  logic         prev_stall = 1'b0;
  logic [255:0] prev_d;
  logic [7:0]   prev_k;
  logic         prev_l;
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      checks++;
      if (!tvalid_out || (data_out !== prev_d) || (tkeep_out !== prev_k) ||
          (tlast_out !== prev_l)) begin
        errors++;
        $display("FAIL stall_stable: got v=%b data=%h keep=%h last=%b, required v=1 data=%h keep=%h last=%b",
                 tvalid_out, data_out, tkeep_out, tlast_out, prev_d, prev_k, prev_l);
      end
    end
    prev_stall <= rst_n && tvalid_out && !tready_in;
    prev_d     <= data_out;
    prev_k     <= tkeep_out;
    prev_l     <= tlast_out;
    if (rst_n && tvalid_in && !tready_out) saw_bp <= 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [255:0] pk8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic exp_w(input logic [31:0] w);
    ew.push_back(w);
  endtask

  // Chop the expected packet word list into output beats
  task automatic exp_end();
    beat_t bt;
    int    n;
    while (ew.size() > 0) begin
      bt = '0;
      n  = 0;
      while ((n < 8) && (ew.size() > 0)) begin
        bt.d[n*32 +: 32] = ew.pop_front();
        n++;
      end
      bt.k = (n == 8) ? 8'hFF : 8'((1 << n) - 1);
      bt.l = (ew.size() == 0);
      sbq.push_back(bt);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat transferred
  task automatic send(input logic [255:0] d, input logic [7:0] k, input logic l, input logic b);
    int n = 0;
    data_in = d; tkeep_in = k; tlast_in = l; bypass = b; tvalid_in = 1'b1;
    @(negedge clk);
    while (!tready_out && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    if (!tready_out) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got tready_out=0 for 200 cycles, required 1");
    end
    @(posedge clk);
    #1;
    tvalid_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (((sbq.size() != 0) || busy) && (n < 1000)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((sbq.size() != 0) || busy) begin
      errors++;
      $display("FAIL %s_drain: got pending=%0d busy=%b, required pending=0 busy=0",
               name, sbq.size(), busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic scenario_one();
    exp_w(32'hFF);
    for (int i = 1; i <= 8; i++) exp_w(i);
    exp_w(8);
    exp_end();
    send(pk8(1, 2, 3, 4, 5, 6, 7, 8), 8'hFF, 1'b1, 1'b0);
    wait_drain("dense_one");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    tvalid_in = 1'b1;
    #1;
    chk("reset_outputs", {tvalid_out, tready_out, tlast_out, busy, tkeep_out}, '0);
    chk("reset_data", 64'(data_out != '0), '0);
    tvalid_in = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", {busy, tready_out}, 64'h1);

    scenario_one();

    // Three all-zero beats: three zero masks plus trailer 24
    exp_w(0); exp_w(0); exp_w(0); exp_w(24);
    exp_end();
    send('0, 8'hFF, 1'b0, 1'b0);
    send('0, 8'hFF, 1'b0, 1'b0);
    send('0, 8'hFF, 1'b1, 1'b0);
    wait_drain("zero_beats");

    // Bypass: zeros kept, no mask or trailer, mid-packet bypass change ignored
    for (int i = 0; i < 8; i++) exp_w((i == 3) ? 32'h0 : 32'hA0 + i);
    exp_w(32'hB0); exp_w(32'hB1); exp_w(32'hB2);
    exp_end();
    send(pk8(32'hA0, 32'hA1, 32'hA2, 32'h0, 32'hA4, 32'hA5, 32'hA6, 32'hA7), 8'hFF, 1'b0, 1'b1);
    send(pk8(32'hB0, 32'hB1, 32'hB2, 32'hB3, 0, 0, 0, 0), 8'h07, 1'b1, 1'b0);
    wait_drain("bypass");

    // Partial keep: word 3 is dropped from mask and count
    exp_w(32'h05); exp_w(3); exp_w(6); exp_w(3);
    exp_end();
    send(pk8(3, 0, 6, 9, 0, 0, 0, 0), 8'h07, 1'b1, 1'b0);
    wait_drain("partial_keep");

    // 16 dense beats with downstream stalled for cycles 5..24
    for (int b = 0; b < 16; b++) begin
      exp_w(32'hFF);
      for (int i = 0; i < 8; i++) exp_w(b * 16 + i + 1);
    end
    exp_w(128);
    exp_end();
    chk("dense_beats_queued", sbq.size(), 19);
    saw_bp   = 1'b0;
    stall_lo = cyc + 5;
    stall_hi = cyc + 24;
    for (int b = 0; b < 16; b++) begin
      send(pk8(b*16+1, b*16+2, b*16+3, b*16+4, b*16+5, b*16+6, b*16+7, b*16+8),
           8'hFF, (b == 15), 1'b0);
    end
    wait_drain("dense_stall");
    chk("backpressure_seen", saw_bp, 1);
    stall_lo = 32'hFFFF_FFFF;

    // Back-to-back packets, second accepted while the first is still finishing
    exp_w(32'h05); exp_w(5); exp_w(7); exp_w(8);
    exp_end();
    exp_w(32'h80); exp_w(9); exp_w(8);
    exp_end();
    send(pk8(5, 0, 7, 0, 0, 0, 0, 0), 8'hFF, 1'b1, 1'b0);
    send(pk8(0, 0, 0, 0, 0, 0, 0, 9), 8'hFF, 1'b1, 1'b0);
    wait_drain("back_to_back");

    // Reset with five words buffered: nothing may come out
    send(pk8(1, 2, 3, 4, 0, 0, 0, 0), 8'hFF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {tvalid_out, tready_out, tlast_out, busy, tkeep_out}, '0);
    chk("midreset_data", 64'(data_out != '0), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    scenario_one();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
